// File: rtl/sy_pkg.sv
// Shared types and widths for the fetch queue.
package sy_pkg;

  localparam int unsigned AWTH = 32;
  localparam int unsigned IWTH = 32;
  localparam int unsigned CAUSE_WTH = 5;

  // Fetch exception descriptor.
  typedef struct packed {
    logic                 valid;
    logic [CAUSE_WTH-1:0] cause;
  } excp_t;

  // One buffered fetch result.
  typedef struct packed {
    logic [AWTH-1:0] pc;
    logic [AWTH-1:0] npc;
    logic [IWTH-1:0] instr;
    logic            is_c;
    excp_t           excp;
  } fq_entry_t;

endpackage

// File: rtl/sy_fifo_ptr.sv
// Pointer and occupancy manager for a power-of-two circular buffer.
// Flush has priority over push/pop and returns everything to zero.
module sy_fifo_ptr #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_WTH = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [CNT_WTH-1:0]       cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_WTH = $clog2(DEPTH);

  // Pointers wrap naturally at DEPTH; count tracks push/pop imbalance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WTH'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_WTH'(1);
        2'b01:   cnt <= cnt - CNT_WTH'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == CNT_WTH'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/sy_ppl_fet_queue.sv
// Fetch-to-decode instruction queue. Stops accepting after a faulting
// entry is queued until the next flush.
// Optional: define SY_FET_QUEUE_BYPASS_EN for a zero-latency path from
// fetch to decode when the queue is empty.
module sy_ppl_fet_queue
  import sy_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_WTH = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               fet_fq__vld_i,
  output logic               fq_fet__rdy_o,
  input  logic [AWTH-1:0]    fet_fq__pc_i,
  input  logic [AWTH-1:0]    fet_fq__npc_i,
  input  logic [IWTH-1:0]    fet_fq__instr_i,
  input  logic               fet_fq__is_compressed_i,
  input  excp_t              fet_fq__excp_i,
  output logic               fq_dec__vld_o,
  input  logic               dec_fq__rdy_i,
  output logic [AWTH-1:0]    fq_dec__pc_o,
  output logic [AWTH-1:0]    fq_dec__npc_o,
  output logic [IWTH-1:0]    fq_dec__instr_o,
  output logic               fq_dec__is_compressed_o,
  output excp_t              fq_dec__excp_o,
  output logic [CNT_WTH-1:0] fq__cnt_o
);

  localparam int unsigned PTR_WTH = $clog2(DEPTH);

  typedef enum logic {FQ_RUN, FQ_FENCE} fq_state_e;

  fq_state_e          state;
  fq_entry_t          mem [DEPTH];
  fq_entry_t          in_entry;
  fq_entry_t          head;
  logic [PTR_WTH-1:0] wr_ptr;
  logic [PTR_WTH-1:0] rd_ptr;
  logic [CNT_WTH-1:0] cnt;
  logic               full;
  logic               empty;
  logic               push_hs;
  logic               push_arr;
  logic               pop_arr;
  logic               byp;

  assign in_entry.pc    = fet_fq__pc_i;
  assign in_entry.npc   = fet_fq__npc_i;
  assign in_entry.instr = fet_fq__instr_i;
  assign in_entry.is_c  = fet_fq__is_compressed_i;
  assign in_entry.excp  = fet_fq__excp_i;

  // Acceptance depends only on registered state and count.
  assign fq_fet__rdy_o = (state == FQ_RUN) && !full;
  assign push_hs       = fet_fq__vld_i && fq_fet__rdy_o;

`ifdef SY_FET_QUEUE_BYPASS_EN
  // Empty queue forwards the fetch entry straight to decode.
  assign byp = empty && (state == FQ_RUN) && !flush_i && fet_fq__vld_i;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry taken by decode never touches the array.
  assign push_arr = push_hs && !(byp && dec_fq__rdy_i);
  assign pop_arr  = !empty && dec_fq__rdy_i;

  sy_fifo_ptr #(
    .DEPTH   (DEPTH),
    .CNT_WTH (CNT_WTH)
  ) u_ptr (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .push   (push_arr),
    .pop    (pop_arr),
    .flush  (flush_i),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .cnt    (cnt),
    .full   (full),
    .empty  (empty)
  );

  // Entry storage; flush leaves contents alone since pointers are reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_arr && !flush_i) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // RUN/FENCE control: fence on a queued fault, release only on flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= FQ_RUN;
    end else begin
      case (state)
        FQ_RUN: begin
          if (!flush_i && push_hs && fet_fq__excp_i.valid) state <= FQ_FENCE;
        end
        FQ_FENCE: begin
          if (flush_i) state <= FQ_RUN;
        end
        default: state <= FQ_RUN;
      endcase
    end
  end

  assign head = byp ? in_entry : mem[rd_ptr];

  assign fq_dec__vld_o           = !empty || byp;
  assign fq_dec__pc_o            = head.pc;
  assign fq_dec__npc_o           = head.npc;
  assign fq_dec__instr_o         = head.instr;
  assign fq_dec__is_compressed_o = head.is_c;
  assign fq_dec__excp_o          = head.excp;
  assign fq__cnt_o               = cnt;

endmodule

// File: tb/tb_sy_ppl_fet_queue.sv
// Directed plus random bench for the fetch queue, checked against a
// queue-based reference model.
module tb_sy_ppl_fet_queue;
  import sy_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_WTH = $clog2(DEPTH) + 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_i;
  logic               fet_fq__vld_i;
  logic               fq_fet__rdy_o;
  logic [AWTH-1:0]    fet_fq__pc_i;
  logic [AWTH-1:0]    fet_fq__npc_i;
  logic [IWTH-1:0]    fet_fq__instr_i;
  logic               fet_fq__is_compressed_i;
  excp_t              fet_fq__excp_i;
  logic               fq_dec__vld_o;
  logic               dec_fq__rdy_i;
  logic [AWTH-1:0]    fq_dec__pc_o;
  logic [AWTH-1:0]    fq_dec__npc_o;
  logic [IWTH-1:0]    fq_dec__instr_o;
  logic               fq_dec__is_compressed_o;
  excp_t              fq_dec__excp_o;
  logic [CNT_WTH-1:0] fq__cnt_o;

  int total = 0;
  int bad   = 0;

  fq_entry_t q[$];
  bit        fence = 1'b0;

  always #5 clk_i = ~clk_i;

  sy_ppl_fet_queue #(.DEPTH(DEPTH), .CNT_WTH(CNT_WTH)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .flush_i                 (flush_i),
    .fet_fq__vld_i           (fet_fq__vld_i),
    .fq_fet__rdy_o           (fq_fet__rdy_o),
    .fet_fq__pc_i            (fet_fq__pc_i),
    .fet_fq__npc_i           (fet_fq__npc_i),
    .fet_fq__instr_i         (fet_fq__instr_i),
    .fet_fq__is_compressed_i (fet_fq__is_compressed_i),
    .fet_fq__excp_i          (fet_fq__excp_i),
    .fq_dec__vld_o           (fq_dec__vld_o),
    .dec_fq__rdy_i           (dec_fq__rdy_i),
    .fq_dec__pc_o            (fq_dec__pc_o),
    .fq_dec__npc_o           (fq_dec__npc_o),
    .fq_dec__instr_o         (fq_dec__instr_o),
    .fq_dec__is_compressed_o (fq_dec__is_compressed_o),
    .fq_dec__excp_o          (fq_dec__excp_o),
    .fq__cnt_o               (fq__cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic fq_entry_t cur_in();
    fq_entry_t e;
    e.pc    = fet_fq__pc_i;
    e.npc   = fet_fq__npc_i;
    e.instr = fet_fq__instr_i;
    e.is_c  = fet_fq__is_compressed_i;
    e.excp  = fet_fq__excp_i;
    return e;
  endfunction

  function automatic bit model_byp();
    bit b;
    b = 1'b0;
`ifdef SY_FET_QUEUE_BYPASS_EN
    b = (q.size() == 0) && !fence && !flush_i && fet_fq__vld_i;
`endif
    return b;
  endfunction

  task automatic drive(input bit v, input bit r, input logic [31:0] pc, input bit ex, input bit fl);
    fet_fq__vld_i           = v;
    dec_fq__rdy_i           = r;
    fet_fq__pc_i            = pc;
    fet_fq__npc_i           = pc + 32'd4;
    fet_fq__instr_i         = $urandom;
    fet_fq__is_compressed_i = 1'($urandom_range(0, 1));
    fet_fq__excp_i.valid    = ex;
    fet_fq__excp_i.cause    = 5'($urandom_range(0, 31));
    flush_i                 = fl;
  endtask

  task automatic check_outputs(input string tag);
    bit        byp;
    bit        ev;
    fq_entry_t h;
    byp = model_byp();
    ev  = (q.size() != 0) || byp;
    chk({tag, ".rdy"}, 64'(fq_fet__rdy_o), 64'(!fence && (q.size() != DEPTH)));
    chk({tag, ".vld"}, 64'(fq_dec__vld_o), 64'(ev));
    chk({tag, ".cnt"}, 64'(fq__cnt_o), 64'(q.size()));
    if (ev) begin
      h = byp ? cur_in() : q[0];
      chk({tag, ".pc"},    64'(fq_dec__pc_o),            64'(h.pc));
      chk({tag, ".npc"},   64'(fq_dec__npc_o),           64'(h.npc));
      chk({tag, ".instr"}, 64'(fq_dec__instr_o),         64'(h.instr));
      chk({tag, ".is_c"},  64'(fq_dec__is_compressed_o), 64'(h.is_c));
      chk({tag, ".excp"},  64'(fq_dec__excp_o),          64'(h.excp));
    end
  endtask

  task automatic model_update();
    bit push;
    bit byp;
    if (flush_i) begin
      q.delete();
      fence = 1'b0;
    end else begin
      push = fet_fq__vld_i && !fence && (q.size() != DEPTH);
      byp  = model_byp();
      if (!(byp && dec_fq__rdy_i)) begin
        if (q.size() != 0 && dec_fq__rdy_i) void'(q.pop_front());
        if (push) q.push_back(cur_in());
      end
      if (push && fet_fq__excp_i.valid) fence = 1'b1;
    end
  endtask

  // Called at a falling edge with inputs set: check, advance model, step a cycle.
  task automatic tick(input string tag);
    #1;
    check_outputs(tag);
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("rst.rdy",   64'(fq_fet__rdy_o), 64'd1);
    chk("rst.vld",   64'(fq_dec__vld_o), 64'd0);
    chk("rst.cnt",   64'(fq__cnt_o), 64'd0);
    chk("rst.pc",    64'(fq_dec__pc_o), 64'd0);
    chk("rst.npc",   64'(fq_dec__npc_o), 64'd0);
    chk("rst.instr", 64'(fq_dec__instr_o), 64'd0);
    chk("rst.is_c",  64'(fq_dec__is_compressed_o), 64'd0);
    chk("rst.excp",  64'(fq_dec__excp_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Fill to DEPTH with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h1000 + 32'(4 * i), 0, 0);
      tick("fill");
    end
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("fill.cnt_full", 64'(fq__cnt_o), 64'd4);
    chk("fill.rdy_full", 64'(fq_fet__rdy_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h0, 0, 0);
      #1;
      chk("drain.order", 64'(fq_dec__pc_o), 64'(32'h1000 + 32'(4 * i)));
      tick("drain");
    end
    drive(0, 0, 32'h0, 0, 0);
    tick("drained");

    // Steady concurrent push/pop at occupancy 2; pointers wrap.
    drive(1, 0, 32'h1100, 0, 0); tick("conc_pre");
    drive(1, 0, 32'h1104, 0, 0); tick("conc_pre");
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 32'h1108 + 32'(4 * i), 0, 0);
      #1;
      chk("conc.cnt", 64'(fq__cnt_o), 64'd2);
      tick("conc");
    end
    drive(0, 1, 32'h0, 0, 0); tick("conc_drain");
    drive(0, 1, 32'h0, 0, 0); tick("conc_drain");

    // Faulting entry fences the input side; decode still drains.
    drive(1, 0, 32'h1200, 0, 0); tick("fence_pre");
    drive(1, 0, 32'h2000, 1, 0); tick("fence_push");
    drive(1, 0, 32'h2004, 0, 0);
    #1;
    chk("fence.rdy", 64'(fq_fet__rdy_o), 64'd0);
    tick("fence_blocked");
    drive(0, 1, 32'h0, 0, 0); tick("fence_drain");
    drive(0, 1, 32'h0, 0, 0);
    #1;
    chk("fence.last_pc", 64'(fq_dec__pc_o), 64'h2000);
    tick("fence_drain");
    drive(0, 1, 32'h0, 0, 0);
    #1;
    chk("fence.empty_vld", 64'(fq_dec__vld_o), 64'd0);
    tick("fence_empty");
    drive(0, 0, 32'h0, 0, 1); tick("fence_flush");
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("fence.rdy_after_flush", 64'(fq_fet__rdy_o), 64'd1);
    tick("fence_idle");

    // Flush beats a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h1300 + 32'(4 * i), 0, 0);
      tick("fl_fill");
    end
    drive(1, 1, 32'h6000, 0, 1); tick("fl_flush");
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("flush.cnt", 64'(fq__cnt_o), 64'd0);
    chk("flush.vld", 64'(fq_dec__vld_o), 64'd0);
    tick("fl_idle");
    drive(1, 0, 32'h5000, 0, 0); tick("fl_push");
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("flush.next_pc", 64'(fq_dec__pc_o), 64'h5000);
    chk("flush.next_cnt", 64'(fq__cnt_o), 64'd1);
    tick("fl_hold");
    drive(0, 0, 32'h0, 0, 1); tick("fl_clear");

    // Asynchronous reset mid-stream.
    drive(1, 0, 32'h1400, 0, 0); tick("rs_fill");
    drive(1, 0, 32'h1404, 0, 0); tick("rs_fill");
    drive(0, 0, 32'h0, 0, 0);
    rst_i = 1'b0;
    q.delete();
    fence = 1'b0;
    #1;
    chk("rst2.rdy", 64'(fq_fet__rdy_o), 64'd1);
    chk("rst2.vld", 64'(fq_dec__vld_o), 64'd0);
    chk("rst2.cnt", 64'(fq__cnt_o), 64'd0);
    chk("rst2.pc",  64'(fq_dec__pc_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 0, 32'h3000, 0, 0); tick("rs_push");
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("rst2.head_vld", 64'(fq_dec__vld_o), 64'd1);
    chk("rst2.head_pc",  64'(fq_dec__pc_o), 64'h3000);
    tick("rs_hold");
    drive(0, 0, 32'h0, 0, 1); tick("rs_clear");

    // Empty queue with both sides ready.
    drive(1, 1, 32'h4000, 0, 0);
    #1;
`ifdef SY_FET_QUEUE_BYPASS_EN
    chk("byp.vld", 64'(fq_dec__vld_o), 64'd1);
    chk("byp.pc",  64'(fq_dec__pc_o), 64'h4000);
`else
    chk("byp.vld", 64'(fq_dec__vld_o), 64'd0);
`endif
    tick("byp");
    drive(0, 0, 32'h0, 0, 0);
    #1;
`ifdef SY_FET_QUEUE_BYPASS_EN
    chk("byp.cnt_after", 64'(fq__cnt_o), 64'd0);
`else
    chk("byp.cnt_after", 64'(fq__cnt_o), 64'd1);
    chk("byp.pc_after",  64'(fq_dec__pc_o), 64'h4000);
`endif
    tick("byp_after");
    drive(0, 1, 32'h0, 0, 0); tick("byp_drain");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), $urandom,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 24) == 0));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sy_ppl_fet_queue.md
Name: sy_ppl_fet_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers per-instruction fetch results (pc, npc, instr, compressed flag, exception) with valid/ready on both sides.
- Decouples fetch-side stalls from decode back-pressure.
- Stops accepting after a faulting instruction is queued, until the next flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_WTH, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush; discards all entries.
- fet_fq__vld_i  in  1  fetch entry valid.
- fq_fet__rdy_o  out  1  queue can accept.
- fet_fq__pc_i  in  AWTH  instruction pc.
- fet_fq__npc_i  in  AWTH  predicted next pc.
- fet_fq__instr_i  in  IWTH  instruction (expanded if compressed).
- fet_fq__is_compressed_i  in  1  original instruction was 16-bit.
- fet_fq__excp_i  in  excp_t  fetch exception.
- fq_dec__vld_o  out  1  head entry valid.
- dec_fq__rdy_i  in  1  decode accepts the head.
- fq_dec__pc_o, fq_dec__npc_o  out  AWTH  head pc / npc.
- fq_dec__instr_o  out  IWTH  head instruction.
- fq_dec__is_compressed_o  out  1  head compressed flag.
- fq_dec__excp_o  out  excp_t  head exception.
- fq__cnt_o  out  CNT_WTH  current occupancy.

Behaviour:
- Storage: DEPTH-entry array; wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; cnt of CNT_WTH bits.
- Push when fet_fq__vld_i && fq_fet__rdy_o. Pop when fq_dec__vld_o && dec_fq__rdy_i.
- fq_fet__rdy_o = (state==RUN) && (cnt != DEPTH).
  - Depends only on registered state.
  - No push while full, even if a pop occurs in the same cycle.
- fq_dec__vld_o = (cnt != 0); head data = array[rd_ptr].
- Simultaneous push and pop: cnt unchanged, both pointers advance.
- Minimum latency is 1 cycle: an entry pushed in cycle N is visible at the head in cycle N+1.
- FSM has two states:
  - RUN: normal operation.
  - FENCE: entered when a pushed entry has excp.valid=1. While in FENCE, rdy_o=0; pops continue and the queue drains normally.
  - FENCE -> RUN only on flush_i.
- Flush is synchronous:
  - In the cycle after flush_i: cnt=0, wr_ptr=rd_ptr=0, state=RUN, vld_o=0.
  - A push or pop coinciding with flush_i is discarded; flush has priority.
  - Array contents are not cleared.
- Reset (rst_i low, any time, including mid-transfer) clears the array to 0, pointers and cnt to 0, state to RUN.
- Reset values of outputs: fq_fet__rdy_o=1, fq_dec__vld_o=0, all data outputs 0, fq__cnt_o=0.
- Back-pressure: head data is held stable while vld_o=1 && rdy_i=0.

Optional Feature:
- Macro SY_FET_QUEUE_BYPASS_EN.
- When defined, zero-latency bypass applies if cnt==0 && state==RUN && !flush_i && fet_fq__vld_i:
  - fq_dec__vld_o=1 and the data outputs mux from the fetch inputs.
  - If dec_fq__rdy_i=1, the entry is consumed without being written; pointers and cnt are unchanged.
  - If dec_fq__rdy_i=0, the entry is written normally.
  - The FENCE transition still applies to a bypassed faulting entry.
- When not defined, the head always comes from the array; minimum latency is 1 cycle.

Decomposition:
- sy_pkg: excp_t (with .valid), AWTH, IWTH, and a new fq_entry_t struct {pc, npc, instr, is_c, excp}.
- The FSM enum {FQ_RUN, FQ_FENCE} is local to the module.
- One natural sub-module: sy_fifo_ptr, the pointer/count manager. It takes push/pop/flush and produces wr_ptr, rd_ptr, cnt, full, empty.

Test Plan:
- Fill test: push pcs 0x1000, 0x1004, 0x1008, 0x100C with decode rdy=0 -> cnt=4, rdy_o=0. Then rdy_i=1 -> pcs pop in order, one per cycle; cnt returns to 0.
- Concurrent push/pop at cnt=2 for 10 cycles -> cnt stays 2. Pointers wrap past DEPTH-1 and the order is preserved.
- Push an entry with excp.valid=1 at pc 0x2000 -> rdy_o=0 next cycle. The queue drains through 0x2000 then vld_o=0. Asserting flush_i -> rdy_o=1 the following cycle.
- Flush with cnt=3 plus a simultaneous push and pop -> next cycle cnt=0, vld_o=0, and no entry from that cycle appears later.
- Assert rst_i low while cnt=2 -> outputs show reset values immediately; after release, first push at 0x3000 is seen at the head one cycle later.
- With SY_FET_QUEUE_BYPASS_EN defined: empty queue, vld_i=1, rdy_i=1, pc 0x4000 -> vld_o=1 and pc_o=0x4000 in the same cycle, cnt stays 0. Without the macro -> head appears the next cycle with cnt=1.
